// File: rtl/fpga_program_sequencer.sv
// Instruction sequencer: fetch / decode / dispatch with step watchdog and exec timeout.
module fpga_program_sequencer #(
  parameter int unsigned IP_WIDTH     = 8,
  parameter int unsigned INSTR_WIDTH  = 32,
  parameter int unsigned MAX_STEPS    = 1024,
  parameter int unsigned EXEC_TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   fetch_req,
  output logic [IP_WIDTH-1:0]    fetch_addr,
  input  logic                   fetch_valid,
  input  logic [INSTR_WIDTH-1:0] fetch_data,
  output logic                   exec_start,
  output logic [INSTR_WIDTH-1:0] exec_instr,
  input  logic                   exec_done,
  input  logic                   exec_result_zero,
  output logic [IP_WIDTH-1:0]    ip,
  output logic                   running,
  output logic                   halted,
  output logic                   fault,
  output logic [2:0]             fault_code,
  output logic [15:0]            steps
);

  localparam int unsigned TW = (EXEC_TIMEOUT > 1) ? $clog2(EXEC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_MAX = TW'(EXEC_TIMEOUT - 1);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_JMP  = 4'd2;
  localparam logic [3:0] OP_JZ   = 4'd3;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [2:0] FC_ILLEGAL = 3'd1;
  localparam logic [2:0] FC_STEPS   = 3'd2;
  localparam logic [2:0] FC_TIMEOUT = 3'd3;
  localparam logic [2:0] FC_IP_OVF  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WAIT_EXEC, S_HALTED, S_FAULT
  } state_t;

  state_t                 state_q, state_d;
  logic [IP_WIDTH-1:0]    ip_q, ip_d;
  logic [15:0]            steps_q, steps_d;
  logic                   zero_q, zero_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [INSTR_WIDTH-1:0] exec_instr_q, exec_instr_d;
  logic                   exec_start_q, exec_start_d;
  logic [2:0]             fault_code_q, fault_code_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic                   fetch_req_q, fetch_req_d;
  logic                   running_q, running_d;
  logic                   halted_q, halted_d;
  logic                   fault_q, fault_d;

  logic [3:0]             opcode;
  logic [IP_WIDTH-1:0]    target;
  logic [IP_WIDTH-1:0]    ip_inc;
  logic [15:0]            steps_inc;
  logic                   step_limit;
  logic                   retire;
  logic                   take_jump;

  assign opcode     = instr_q[INSTR_WIDTH-1 -: 4];
  assign target     = instr_q[IP_WIDTH-1:0];
  assign ip_inc     = ip_q + IP_WIDTH'(1);
  assign steps_inc  = (&steps_q) ? steps_q : steps_q + 16'd1;
  assign step_limit = (32'(steps_inc) == MAX_STEPS);

  // Next-state, datapath and output-register inputs
  always_comb begin
    state_d      = state_q;
    ip_d         = ip_q;
    steps_d      = steps_q;
    zero_d       = zero_q;
    instr_d      = instr_q;
    exec_instr_d = exec_instr_q;
    exec_start_d = 1'b0;
    fault_code_d = fault_code_q;
    tcnt_d       = tcnt_q;
    retire       = 1'b0;
    take_jump    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          ip_d    = '0;
          steps_d = '0;
          zero_d  = 1'b0;
        end
      end
      S_FETCH: begin
        if (fetch_valid) begin
          instr_d = fetch_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP: retire = 1'b1;
          OP_ADD: begin
            state_d      = S_WAIT_EXEC;
            exec_start_d = 1'b1;
            exec_instr_d = instr_q;
            tcnt_d       = '0;
          end
          OP_JMP: begin
            retire    = 1'b1;
            take_jump = 1'b1;
          end
          OP_JZ: begin
            retire    = 1'b1;
            take_jump = zero_q;
          end
          OP_HALT: begin
            steps_d = steps_inc;
            state_d = S_HALTED;
          end
          default: begin
            state_d      = S_FAULT;
            fault_code_d = FC_ILLEGAL;
          end
        endcase
      end
      S_WAIT_EXEC: begin
        if (exec_done) begin
          zero_d = exec_result_zero;
          retire = 1'b1;
        end else if (tcnt_q == TCNT_MAX) begin
          state_d      = S_FAULT;
          fault_code_d = FC_TIMEOUT;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: ;
    endcase

    // Retirement: count, then watchdog, then ip overflow, else advance
    if (retire) begin
      steps_d = steps_inc;
      if (step_limit) begin
        state_d      = S_FAULT;
        fault_code_d = FC_STEPS;
      end else if (!take_jump && (&ip_q)) begin
        state_d      = S_FAULT;
        fault_code_d = FC_IP_OVF;
      end else begin
        ip_d    = take_jump ? target : ip_inc;
        state_d = S_FETCH;
      end
    end

    fetch_req_d = (state_d == S_FETCH);
    running_d   = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_WAIT_EXEC);
    halted_d    = (state_d == S_HALTED);
    fault_d     = (state_d == S_FAULT);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ip_q         <= '0;
      steps_q      <= '0;
      zero_q       <= 1'b0;
      instr_q      <= '0;
      exec_instr_q <= '0;
      exec_start_q <= 1'b0;
      fault_code_q <= '0;
      tcnt_q       <= '0;
      fetch_req_q  <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ip_q         <= ip_d;
      steps_q      <= steps_d;
      zero_q       <= zero_d;
      instr_q      <= instr_d;
      exec_instr_q <= exec_instr_d;
      exec_start_q <= exec_start_d;
      fault_code_q <= fault_code_d;
      tcnt_q       <= tcnt_d;
      fetch_req_q  <= fetch_req_d;
      running_q    <= running_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
    end
  end

  assign fetch_req  = fetch_req_q;
  assign fetch_addr = ip_q;
  assign exec_start = exec_start_q;
  assign exec_instr = exec_instr_q;
  assign ip         = ip_q;
  assign running    = running_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign steps      = steps_q;

endmodule

// File: tb/tb_fpga_program_sequencer.sv
// Scoreboard bench for fpga_program_sequencer: main instance plus small-parameter instances.
module tb_fpga_program_sequencer;

  localparam int unsigned TO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        fetch_req, fetch_valid;
  logic [7:0]  fetch_addr;
  logic [31:0] fetch_data;
  logic        exec_start, exec_done, exec_result_zero;
  logic [31:0] exec_instr;
  logic [7:0]  ip;
  logic        running, halted, fault;
  logic [2:0]  fault_code;
  logic [15:0] steps;

  always #5 clock = ~clock;

  logic [31:0] mem [256];
  int          stall_left = 0;

  assign fetch_data  = mem[fetch_addr];
  assign fetch_valid = fetch_req && (stall_left == 0);

  fpga_program_sequencer #(.IP_WIDTH(8), .INSTR_WIDTH(32), .MAX_STEPS(1024), .EXEC_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .exec_start(exec_start), .exec_instr(exec_instr), .exec_done(exec_done),
    .exec_result_zero(exec_result_zero), .ip(ip), .running(running), .halted(halted),
    .fault(fault), .fault_code(fault_code), .steps(steps));

  // Step-watchdog instance: MAX_STEPS=4, memory always answers in one cycle
  logic        start_s = 1'b0;
  logic        fetch_req_s, exec_start_s, running_s, halted_s, fault_s;
  logic [7:0]  fetch_addr_s, ip_s;
  logic [31:0] exec_instr_s;
  logic [2:0]  fault_code_s;
  logic [15:0] steps_s;
  logic [31:0] mem_s [256];
  logic        zero_in = 1'b0;

  fpga_program_sequencer #(.IP_WIDTH(8), .INSTR_WIDTH(32), .MAX_STEPS(4), .EXEC_TIMEOUT(TO)) dut_s (
    .clock(clock), .reset(reset), .start(start_s),
    .fetch_req(fetch_req_s), .fetch_addr(fetch_addr_s), .fetch_valid(fetch_req_s),
    .fetch_data(mem_s[fetch_addr_s]),
    .exec_start(exec_start_s), .exec_instr(exec_instr_s), .exec_done(zero_in),
    .exec_result_zero(zero_in), .ip(ip_s), .running(running_s), .halted(halted_s),
    .fault(fault_s), .fault_code(fault_code_s), .steps(steps_s));

  // IP-overflow instance: IP_WIDTH=2
  logic        start_o = 1'b0;
  logic        fetch_req_o, exec_start_o, running_o, halted_o, fault_o;
  logic [1:0]  fetch_addr_o, ip_o;
  logic [31:0] exec_instr_o;
  logic [2:0]  fault_code_o;
  logic [15:0] steps_o;
  logic [31:0] mem_o [4];

  fpga_program_sequencer #(.IP_WIDTH(2), .INSTR_WIDTH(32), .MAX_STEPS(1024), .EXEC_TIMEOUT(TO)) dut_o (
    .clock(clock), .reset(reset), .start(start_o),
    .fetch_req(fetch_req_o), .fetch_addr(fetch_addr_o), .fetch_valid(fetch_req_o),
    .fetch_data(mem_o[fetch_addr_o]),
    .exec_start(exec_start_o), .exec_instr(exec_instr_o), .exec_done(zero_in),
    .exec_result_zero(zero_in), .ip(ip_o), .running(running_o), .halted(halted_o),
    .fault(fault_o), .fault_code(fault_code_o), .steps(steps_o));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Scoreboard records: exec dispatch or program end
  typedef struct {
    bit          is_end;
    logic [31:0] ip;
    logic [31:0] instr;
    logic        halt;
    logic [2:0]  code;
    logic [15:0] steps;
  } exp_t;

  exp_t        sb_q [$];
  logic [7:0]  fetch_q [$];

  typedef struct { int lat; bit zero; } plan_t;
  plan_t       plan_q [$];
  int          exec_pend = 0;
  bit          pend_zero = 1'b0;

  task automatic push_exec(input logic [7:0] a, input logic [31:0] w);
    exp_t e;
    e = '{is_end: 1'b0, ip: 32'(a), instr: w, halt: 1'b0, code: 3'd0, steps: 16'd0};
    sb_q.push_back(e);
  endtask

  task automatic push_end(input logic h, input logic [2:0] c, input logic [7:0] a, input logic [15:0] s);
    exp_t e;
    e = '{is_end: 1'b1, ip: 32'(a), instr: 32'd0, halt: h, code: c, steps: s};
    sb_q.push_back(e);
  endtask

  // Execution-unit model: done after a planned latency (0 = same cycle as exec_start, <0 = never)
  initial begin
    exec_done = 1'b0;
    exec_result_zero = 1'b0;
    forever begin
      @(negedge clock);
      exec_done = 1'b0;
      if (exec_pend > 0) begin
        exec_pend--;
        if (exec_pend == 0) begin
          exec_done = 1'b1;
          exec_result_zero = pend_zero;
        end
      end
      if (exec_start && plan_q.size() > 0) begin
        plan_t p;
        p = plan_q.pop_front();
        if (p.lat == 0) begin
          exec_done = 1'b1;
          exec_result_zero = p.zero;
        end else if (p.lat > 0) begin
          exec_pend = p.lat;
          pend_zero = p.zero;
        end
      end
    end
  end

  // Fetch stall: valid is held low while stall_left counts down over FETCH cycles
  initial forever begin
    @(negedge clock);
    if (fetch_req && stall_left > 0) stall_left--;
  end

  // Monitor: compares DUT events against the scoreboard
  logic        halted_p = 1'b0, fault_p = 1'b0;
  logic [31:0] last_instr = '0;
  initial forever begin
    @(negedge clock);
    #1;
    if (fetch_req && fetch_valid) begin
      if (fetch_q.size() == 0) chk("fetch_unexpected", 32'(fetch_addr), 32'hFFFF_FFFF);
      else chk("fetch_addr", 32'(fetch_addr), 32'(fetch_q.pop_front()));
    end
    if (exec_start) begin
      last_instr = exec_instr;
      if (sb_q.size() == 0 || sb_q[0].is_end) chk("exec_unexpected", 32'(ip), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("exec_ip", 32'(ip), e.ip);
        chk("exec_instr", exec_instr, e.instr);
        chk("exec_running", 32'(running), 32'd1);
      end
    end
    if (exec_done && running && !reset) chk("exec_instr_stable", exec_instr, last_instr);
    if ((halted && !halted_p) || (fault && !fault_p)) begin
      if (sb_q.size() == 0 || !sb_q[0].is_end) chk("end_unexpected", 32'(ip), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("end_halted", 32'(halted), 32'(e.halt));
        chk("end_fault", 32'(fault), 32'(!e.halt));
        chk("end_fault_code", 32'(fault_code), 32'(e.code));
        chk("end_ip", 32'(ip), e.ip);
        chk("end_steps", 32'(steps), 32'(e.steps));
        chk("end_running", 32'(running), 32'd0);
      end
    end
    halted_p = halted;
    fault_p  = fault;
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    stall_left = 0;
    plan_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h7000_0000;
  endtask

  task automatic wait_end(input string name, input int budget);
    int n = 0;
    while (!(halted || fault) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(halted || fault), 32'd1);
  endtask

  task automatic sb_drained(input string name);
    @(negedge clock);
    #2;
    chk(name, 32'(sb_q.size() + fetch_q.size()), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, {fetch_req, exec_start, running, halted, fault, fault_code, 8'(ip), 16'(steps)}, 32'd0);
    chk({name, "_instr"}, exec_instr, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_s[i] = 32'h2000_0000;
    for (int i = 0; i < 4; i++) mem_o[i] = 32'h0000_0000;
    clear_mem();
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state
    chk_idle_outputs("reset_state");
    chk("reset_fetch_addr", 32'(fetch_addr), 32'd0);

    // Add program: ADD, ADD, HALT; memory 1 cycle, done 3 cycles after start
    mem[0] = 32'h1000_00AB; mem[1] = 32'h1234_5678; mem[2] = 32'hF000_0000;
    plan_q.push_back('{3, 1'b0}); plan_q.push_back('{3, 1'b0});
    fetch_q = '{8'd0, 8'd1, 8'd2};
    push_exec(8'd0, 32'h1000_00AB);
    push_exec(8'd1, 32'h1234_5678);
    push_end(1'b1, 3'd0, 8'd2, 16'd3);
    pulse_start();
    wait_end("add_done", 100);
    sb_drained("add_drained");

    // Loop: ADD, JZ 4, JMP 0, (illegal), HALT; zero=0 then zero=1
    do_reset();
    clear_mem();
    mem[0] = 32'h1000_0000; mem[1] = 32'h3000_0004; mem[2] = 32'h2000_0000; mem[4] = 32'hF000_0000;
    plan_q.push_back('{0, 1'b0}); plan_q.push_back('{2, 1'b1});
    fetch_q = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd4};
    push_exec(8'd0, 32'h1000_0000);
    push_exec(8'd0, 32'h1000_0000);
    push_end(1'b1, 3'd0, 8'd4, 16'd6);
    pulse_start();
    wait_end("loop_done", 200);
    sb_drained("loop_drained");

    // Illegal opcode after a NOP
    do_reset();
    clear_mem();
    mem[0] = 32'h0000_0000; mem[1] = 32'h7000_0000;
    fetch_q = '{8'd0, 8'd1};
    push_end(1'b0, 3'd1, 8'd1, 16'd1);
    pulse_start();
    wait_end("illegal_done", 100);
    sb_drained("illegal_drained");

    // Execution timeout
    do_reset();
    clear_mem();
    mem[0] = 32'h1000_0000; mem[1] = 32'hF000_0000;
    plan_q.push_back('{-1, 1'b0});
    fetch_q = '{8'd0};
    push_exec(8'd0, 32'h1000_0000);
    push_end(1'b0, 3'd3, 8'd0, 16'd0);
    pulse_start();
    begin
      int n = 0;
      while (!exec_start && n < 20) begin @(negedge clock); n++; end
      chk("timeout_start_seen", 32'(exec_start), 32'd1);
      n = 0;
      while (!fault && n < 40) begin @(negedge clock); n++; end
      chk("timeout_cycles", 32'(n), 32'(TO));
    end
    sb_drained("timeout_drained");

    // Fetch stall of 10 cycles, then reset during WAIT_EXEC with a late done
    do_reset();
    clear_mem();
    mem[0] = 32'h1000_0055;
    plan_q.push_back('{8, 1'b1});
    fetch_q = '{8'd0};
    push_exec(8'd0, 32'h1000_0055);
    stall_left = 11;
    @(negedge clock);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      start = 1'b0;
      chk("stall_req", 32'(fetch_req), 32'd1);
      chk("stall_addr", 32'(fetch_addr), 32'd0);
    end
    begin
      int n = 0;
      while (!exec_start && n < 20) begin @(negedge clock); n++; end
      chk("stall_exec_seen", 32'(exec_start), 32'd1);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk_idle_outputs("midexec_reset_idle");
    end
    sb_drained("midexec_drained");

    // Restart from ip=0 after the abandoned program
    mem[0] = 32'h0000_0000; mem[1] = 32'hF000_0000;
    fetch_q = '{8'd0, 8'd1};
    push_end(1'b1, 3'd0, 8'd1, 16'd2);
    pulse_start();
    wait_end("restart_done", 100);
    sb_drained("restart_drained");

    // Start while HALTED is ignored
    pulse_start();
    repeat (5) @(negedge clock);
    chk("halted_sticky", {29'd0, halted, fault, fetch_req}, 32'd4);
    chk("halted_ip", 32'(ip), 32'd1);
    chk("halted_steps", 32'(steps), 32'd2);
    chk("halted_code", 32'(fault_code), 32'd0);

    // Step limit: MAX_STEPS=4 with JMP 0 forever
    @(negedge clock); start_s = 1'b1;
    @(negedge clock); start_s = 1'b0;
    begin
      int n = 0;
      while (!fault_s && n < 100) begin @(negedge clock); n++; end
    end
    chk("steps_fault", 32'(fault_s), 32'd1);
    chk("steps_code", 32'(fault_code_s), 32'd2);
    chk("steps_count", 32'(steps_s), 32'd4);
    chk("steps_ip", 32'(ip_s), 32'd0);

    // IP overflow: IP_WIDTH=2, four NOPs
    @(negedge clock); start_o = 1'b1;
    @(negedge clock); start_o = 1'b0;
    begin
      int n = 0;
      while (!fault_o && n < 100) begin @(negedge clock); n++; end
    end
    chk("ovf_fault", 32'(fault_o), 32'd1);
    chk("ovf_code", 32'(fault_code_o), 32'd4);
    chk("ovf_ip", 32'(ip_o), 32'd3);
    chk("ovf_steps", 32'(steps_o), 32'd4);
    @(negedge clock); start_o = 1'b1;
    @(negedge clock); start_o = 1'b0;
    repeat (4) @(negedge clock);
    chk("ovf_sticky", {29'd0, fault_o, running_o, halted_o}, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpga_program_sequencer.md
Name: fpga_program_sequencer

Overview:
Instruction sequencer for the FPGA test programs (Add and successors). Owns the instruction pointer: fetches instruction words from a program memory over a request/valid handshake, decodes them, dispatches arithmetic operations to a single shared execution unit over a start/done handshake, and resolves jumps and halt. A step watchdog and an execution timeout turn hung programs into a reported fault rather than a silent stall.

Parameters:
IP_WIDTH, 8, instruction pointer / program address width
INSTR_WIDTH, 32, instruction word width (minimum 16)
MAX_STEPS, 1024, retired-instruction limit before fault
EXEC_TIMEOUT, 16, cycles allowed between exec_start and exec_done

Ports:
clock  input  1  driving clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin program at ip=0; honoured only in IDLE
fetch_req  output  1  instruction fetch request, held until fetch_valid
fetch_addr  output  IP_WIDTH  address of requested instruction (equals ip)
fetch_valid  input  1  fetch_data valid; sampled only while fetch_req=1
fetch_data  input  INSTR_WIDTH  instruction word
exec_start  output  1  one-cycle pulse dispatching an operation
exec_instr  output  INSTR_WIDTH  registered instruction word for execution unit, stable from exec_start until exec_done
exec_done  input  1  operation complete; sampled only in WAIT_EXEC
exec_result_zero  input  1  result==0 flag, valid with exec_done
ip  output  IP_WIDTH  current instruction pointer
running  output  1  high in every state except IDLE, HALTED, FAULT
halted  output  1  program reached HALT
fault  output  1  program aborted
fault_code  output  3  1 illegal opcode, 2 step limit, 3 exec timeout, 4 ip overflow
steps  output  16  retired-instruction count

Behaviour:
- Reset (any state, incl. mid-fetch/mid-exec): state IDLE; ip=0, steps=0, zero flag=0; all outputs 0; exec_instr=0. A pending fetch or exec is abandoned; late fetch_valid/exec_done ignored.
- Opcode = instr[INSTR_WIDTH-1 -: 4]; target = instr[IP_WIDTH-1:0]. 0 NOP; 1 ADD (dispatch); 2 JMP; 3 JZ (jump if zero flag=1); 15 HALT; others illegal.
- States: IDLE, FETCH, DECODE, WAIT_EXEC, HALTED, FAULT.
- IDLE: start=1 -> FETCH next cycle, ip=0, steps=0, zero flag cleared.
- FETCH: fetch_req=1, fetch_addr=ip. Cycle with fetch_valid=1: capture fetch_data, fetch_req drops next cycle, -> DECODE. Minimum fetch latency is 1 cycle (valid in first FETCH cycle).
- DECODE (1 cycle): NOP: ip+1 -> FETCH. ADD: exec_start=1 for exactly this cycle's following edge-to-edge cycle (registered), -> WAIT_EXEC. JMP: ip=target -> FETCH. JZ: ip = zero?target:ip+1 -> FETCH. HALT: -> HALTED, ip unchanged. Illegal: -> FAULT code 1, ip left at faulting instruction.
- WAIT_EXEC: exec_done=1 -> latch zero flag from exec_result_zero, ip+1, -> FETCH. exec_done in same cycle as the exec_start pulse is accepted. Timeout counter counts cycles in WAIT_EXEC; reaching EXEC_TIMEOUT without done -> FAULT code 3.
- Retirement: steps+1 on each NOP/JMP/JZ decode, ADD exec_done, and HALT. Retiring a non-HALT instruction that makes steps==MAX_STEPS -> FAULT code 2 instead of FETCH. Steps saturates at 16'hFFFF.
- ip increment from all-ones (ip+1 wraps) -> FAULT code 4; jumps never overflow.
- Priority on one edge: reset > fault > normal transition. Timeout and done in same cycle: done wins.
- HALTED/FAULT: sticky; outputs hold; start ignored; only reset leaves. fault_code=0 unless fault=1.
- FETCH cycle count per NOP with 1-cycle memory: 2 cycles/instruction (FETCH, DECODE).

Test Plan:
- Add program: [0]=ADD,[1]=ADD,[2]=HALT, memory valid 1 cycle, exec_done 3 cycles after start -> two exec_start pulses, halted=1, ip=2, steps=3, fault=0.
- Loop: [0]=ADD,[1]=JZ 4,[2]=JMP 0,[4]=HALT; first done zero=0, second zero=1 -> ip sequence 0,1,2,0,1,4; halted, steps=6.
- Illegal: [0]=NOP,[1]=opcode 7 -> fault=1, fault_code=1, ip=1, steps=1, no exec_start.
- Timeout: [0]=ADD, exec_done never asserted -> fault_code=3 exactly EXEC_TIMEOUT cycles after entering WAIT_EXEC; MAX_STEPS=4 with [0]=JMP 0 -> fault_code=2, steps=4.
- Stall and reset: fetch_valid withheld 10 cycles -> fetch_req/fetch_addr stable; reset asserted during WAIT_EXEC, exec_done then pulsed -> IDLE, all outputs 0, done ignored; start restarts from ip=0.
- Overflow: IP_WIDTH=2, four NOPs -> fault_code=4 at ip=3; start while HALTED ignored.
